// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared definitions for the PWM peripheral: default counter and prescale
// widths and the counting-direction encoding. The register block imports
// this package as well, so both sides agree on field widths and on the
// meaning of the upnotdown bit.
package pwm_pkg;

    localparam int COUNTER_W  = 16;
    localparam int PRESCALE_W = 8;

    // Encoding matches the upnotdown bit of the register block directly.
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } counter_dir_e;

endpackage : pwm_pkg

// File: rtl/pwm_prescaler.sv
// pwm_prescaler
// Clock divider for the PWM timebase. It produces a one-clock tick once
// every prescale+1 enabled clocks.
//
// Ports:
//   clk       in   peripheral clock, rising edge
//   rst       in   synchronous active-high reset
//   en        in   count enable; psc_cnt holds while low
//   clr       in   synchronous clear of psc_cnt (count_reset from the top)
//   prescale  in   divide value; tick every prescale+1 enabled clocks
//   tick      out  combinational, high on the enabled clock that advances
//                  the counter
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESCALE_W = pwm_pkg::PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] psc_cnt;

    // A >= compare, not ==, so that lowering prescale below the current
    // psc_cnt ticks on the next clock instead of running through 2^W.
    // Because psc_cnt only increments while it is below prescale, it never
    // exceeds the largest prescale value and cannot overflow.
    assign tick = en && (psc_cnt >= prescale);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            psc_cnt <= '0;
        end else if (en) begin
            if (tick) begin
                psc_cnt <= '0;
            end else begin
                psc_cnt <= psc_cnt + PRESCALE_W'(1);
            end
        end
    end

endmodule : pwm_prescaler

// File: rtl/pwm_counter.sv
// pwm_counter
// Programmable up/down timebase for the PWM generator. It counts within
// 0..period at the rate set by the prescaler. It pulses cycle_end for one
// clock at each wrap so that the comparator stage can reload its compare
// values.
//
// Ports:
//   clk          in   peripheral clock, rising edge
//   rst          in   synchronous active-high reset
//   en           in   count enable (level)
//   count_reset  in   level; clears counter, prescaler and cycle_end
//   upnotdown    in   1 = count up, 0 = count down
//   period       in   terminal value, range is 0..period inclusive
//   prescale     in   counter advances once every prescale+1 clocks
//   counter_val  out  current count, registered
//   cycle_end    out  registered one-clock pulse, coincident with the
//                     wrapped counter value
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int COUNTER_W  = pwm_pkg::COUNTER_W,
    parameter int PRESCALE_W = pwm_pkg::PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  count_reset,
    input  logic                  upnotdown,
    input  logic [COUNTER_W-1:0]  period,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [COUNTER_W-1:0]  counter_val,
    output logic                  cycle_end
);

    logic                 tick;
    counter_dir_e         dir;
    logic [COUNTER_W-1:0] next_val;
    logic                 wrap;

    assign dir = counter_dir_e'(upnotdown);

    pwm_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (count_reset),
        .prescale (prescale),
        .tick     (tick)
    );

    // Next counter value for a tick. Wraps are driven only by period, and
    // the counter never passes through 2^W. A count left above a reduced
    // period snaps back into range: in up mode the >= compare wraps it to
    // 0 with a pulse. In down mode it is clamped to period without a
    // pulse, because it has not completed a cycle.
    always_comb begin
        next_val = counter_val;
        wrap     = 1'b0;
        if (dir == DIR_UP) begin
            if (counter_val >= period) begin
                next_val = '0;
                wrap     = 1'b1;
            end else begin
                next_val = counter_val + COUNTER_W'(1);
            end
        end else begin
            if (counter_val == '0) begin
                next_val = period;
                wrap     = 1'b1;
            end else if (counter_val > period) begin
                next_val = period;
            end else begin
                next_val = counter_val - COUNTER_W'(1);
            end
        end
    end

    // Resets take priority over a wrap on the same edge, so cycle_end stays
    // low in that case. The tick input already includes en.
    always_ff @(posedge clk) begin
        if (rst || count_reset) begin
            counter_val <= '0;
            cycle_end   <= 1'b0;
        end else if (tick) begin
            counter_val <= next_val;
            cycle_end   <= wrap;
        end else begin
            cycle_end   <= 1'b0;
        end
    end

endmodule : pwm_counter

// File: tb/tb_pwm_counter.sv
// tb_pwm_counter
// Self-checking bench for pwm_counter. It runs directed sequences from the
// test plan and then randomized traffic. Every clock, both outputs are
// compared against a behavioural model that works on plain integers.
module tb_pwm_counter;

    localparam int CW = 16;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          count_reset = 1'b0;
    logic          upnotdown = 1'b1;
    logic [CW-1:0] period = '0;
    logic [PW-1:0] prescale = '0;
    logic [CW-1:0] counter_val;
    logic          cycle_end;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int  m_cnt = 0;
    int  m_psc = 0;
    bit  m_ce  = 1'b0;

    always #5 clk = ~clk;

    pwm_counter #(
        .COUNTER_W  (CW),
        .PRESCALE_W (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .count_reset (count_reset),
        .upnotdown   (upnotdown),
        .period      (period),
        .prescale    (prescale),
        .counter_val (counter_val),
        .cycle_end   (cycle_end)
    );

    task automatic checkOutput(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // The model advances one clock using the rules of the timebase.
    task automatic modelStep();
        bit tk;
        if (rst || count_reset) begin
            m_cnt = 0;
            m_psc = 0;
            m_ce  = 0;
        end else if (!en) begin
            m_ce = 0;
        end else begin
            tk = (m_psc >= int'(prescale));
            m_psc = tk ? 0 : m_psc + 1;
            m_ce = 0;
            if (tk) begin
                if (upnotdown) begin
                    if (m_cnt >= int'(period)) begin
                        m_cnt = 0;
                        m_ce  = 1;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end else begin
                    if (m_cnt == 0) begin
                        m_cnt = int'(period);
                        m_ce  = 1;
                    end else if (m_cnt > int'(period)) begin
                        m_cnt = int'(period);
                    end else begin
                        m_cnt = m_cnt - 1;
                    end
                end
            end
        end
    endtask

    // The task drives one clock of inputs, steps the model on the edge, and
    // compares both outputs 1 ns after the edge.
    task automatic applyStimulus(input bit r, input bit cr, input bit e,
                                 input bit up, input int per, input int psc,
                                 input string tag);
        rst         = r;
        count_reset = cr;
        en          = e;
        upnotdown   = up;
        period      = CW'(per);
        prescale    = PW'(psc);
        @(posedge clk);
        modelStep();
        #1;
        checkOutput({tag, ".cnt"}, int'(counter_val), m_cnt);
        checkOutput({tag, ".ce"}, int'(cycle_end), int'(m_ce));
    endtask

    int exp_up[6]   = '{1, 2, 3, 4, 0, 1};
    int exp_dn[7]   = '{5, 4, 3, 2, 1, 0, 5};
    int ce_count;

    initial begin
        // Reset state
        applyStimulus(1, 0, 0, 1, 0, 0, "reset");
        checkOutput("reset_cnt_const", int'(counter_val), 0);
        checkOutput("reset_ce_const", int'(cycle_end), 0);

        // Up, period 4, prescale 0
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 1, 1, 4, 0, "up4");
            checkOutput($sformatf("up4_seq%0d", i), int'(counter_val), exp_up[i]);
            checkOutput($sformatf("up4_ce%0d", i), int'(cycle_end), (exp_up[i] == 0) ? 1 : 0);
        end

        // Up, period 3, prescale 2: a wrap after 12 clocks with one pulse
        applyStimulus(0, 1, 1, 1, 3, 2, "clr");
        ce_count = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 0, 1, 1, 3, 2, "up3p2");
            ce_count += int'(cycle_end);
            if (i == 2) checkOutput("up3p2_first", int'(counter_val), 1);
        end
        checkOutput("up3p2_wrap", int'(counter_val), 0);
        checkOutput("up3p2_pulses", ce_count, 1);

        // Down, period 5, starting from 0
        applyStimulus(0, 1, 1, 0, 5, 0, "clr");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 0, 1, 0, 5, 0, "dn5");
            checkOutput($sformatf("dn5_seq%0d", i), int'(counter_val), exp_dn[i]);
            checkOutput($sformatf("dn5_ce%0d", i), int'(cycle_end), (i == 0 || i == 6) ? 1 : 0);
        end

        // Period reduced below the count, in up mode and in down mode
        applyStimulus(0, 1, 1, 1, 20, 0, "clr");
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 1, 20, 0, "to10");
        checkOutput("at10_up", int'(counter_val), 10);
        applyStimulus(0, 0, 1, 1, 6, 0, "shrink_up");
        checkOutput("shrink_up_val", int'(counter_val), 0);
        checkOutput("shrink_up_ce", int'(cycle_end), 1);
        applyStimulus(0, 1, 1, 1, 20, 0, "clr");
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 1, 20, 0, "to10");
        applyStimulus(0, 0, 1, 0, 6, 0, "shrink_dn");
        checkOutput("shrink_dn_val", int'(counter_val), 6);
        checkOutput("shrink_dn_ce", int'(cycle_end), 0);

        // en dropped mid-prescale: prescale 3, psc_cnt 2
        applyStimulus(0, 1, 1, 1, 10, 3, "clr");
        applyStimulus(0, 0, 1, 1, 10, 3, "pre");
        applyStimulus(0, 0, 1, 1, 10, 3, "pre");
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 1, 10, 3, "hold");
        checkOutput("hold_val", int'(counter_val), 0);
        applyStimulus(0, 0, 1, 1, 10, 3, "resume1");
        checkOutput("resume1_val", int'(counter_val), 0);
        applyStimulus(0, 0, 1, 1, 10, 3, "resume2");
        checkOutput("resume2_val", int'(counter_val), 1);

        // count_reset at count 9, on a wrap edge, and rst mid-count
        applyStimulus(0, 1, 1, 1, 20, 0, "clr");
        for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 1, 20, 0, "to9");
        applyStimulus(0, 1, 1, 1, 20, 0, "cr_at9");
        checkOutput("cr_at9_val", int'(counter_val), 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 3, 0, "to3");
        applyStimulus(0, 1, 1, 1, 3, 0, "cr_wrap");
        checkOutput("cr_wrap_ce", int'(cycle_end), 0);
        applyStimulus(0, 0, 1, 1, 3, 0, "after_cr");
        checkOutput("after_cr_val", int'(counter_val), 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1, 20, 1, "pre_rst");
        applyStimulus(1, 0, 1, 1, 20, 1, "rst_mid");
        checkOutput("rst_mid_val", int'(counter_val), 0);

        // Period 0 in both directions
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1, 0, 0, "p0_up");
        checkOutput("p0_up_ce", int'(cycle_end), 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0, 1, "p0_dn");

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            automatic bit r  = ($urandom_range(99) < 2);
            automatic bit cr = ($urandom_range(99) < 3);
            automatic bit e  = ($urandom_range(99) < 85);
            automatic bit up = (i % 200 < 120) ? ($urandom_range(99) < 95)
                                               : ($urandom_range(99) < 10);
            automatic int per = ($urandom_range(19) == 0) ? int'($urandom_range(65535))
                                                          : int'($urandom_range(12));
            automatic int psc = ($urandom_range(9) == 0) ? int'($urandom_range(255))
                                                         : int'($urandom_range(3));
            applyStimulus(r, cr, e, up, per, psc, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pwm_counter

// File: doc/pwm_counter.md
# pwm_counter

Programmable 16-bit timebase for the PWM generator. Sits directly downstream of the register block. Consumes its counter programming outputs (`period`, `en`, `count_reset`, `upnotdown`, `prescale`) and produces `counter_val`. `counter_val` feeds back to the register block for readback and forward to the PWM comparator stage. It also emits a one-cycle `cycle_end` pulse at every period wrap, so the PWM stage can reload its compare values.

## Interface

Parameters:
- `COUNTER_W`, 16: counter and period width.
- `PRESCALE_W`, 8: prescale field width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: peripheral clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: count enable (level).
- `count_reset`  in  1: level; clears the counter and the prescaler while high.
- `upnotdown`  in  1: 1 = count up, 0 = count down.
- `period`  in  `COUNTER_W`: terminal value; counting range is 0..`period` inclusive.
- `prescale`  in  `PRESCALE_W`: counter advances once every `prescale`+1 clocks.
- `counter_val`  out  `COUNTER_W`: current count, registered.
- `cycle_end`  out  1: registered pulse marking a wrap.

## Operation

- Reset values: `counter_val`=0, `cycle_end`=0, internal `psc_cnt`=0.
- Priority is `rst` > `count_reset` > `en`.
- `count_reset`=1: `counter_val`←0, `psc_cnt`←0, `cycle_end`←0, regardless of `en`.
- `en`=0 (no reset): `counter_val` and `psc_cnt` hold; `cycle_end`←0.
- Prescaler, when `en`=1:
  - `tick`=(`psc_cnt` >= `prescale`).
  - On `tick`, `psc_cnt`←0; otherwise `psc_cnt`←`psc_cnt`+1.
  - The `>=` compare means a `prescale` reduced below the current `psc_cnt` ticks on the next cycle.
- Up mode, on `tick`:
  - If `counter_val` >= `period`: `counter_val`←0, `cycle_end`←1.
  - Else: `counter_val`←`counter_val`+1.
- Down mode, on `tick`:
  - If `counter_val`==0: `counter_val`←`period`, `cycle_end`←1.
  - Else if `counter_val` > `period`: `counter_val`←`period`, no pulse.
  - Else: `counter_val`←`counter_val`-1.
- No `tick`: `cycle_end`←0.
- Arithmetic is unsigned `COUNTER_W`. No wrap through 2^16 is ever produced; wraps are governed only by `period`.
- `period`=0: `counter_val` stays 0, and `cycle_end` pulses on every tick.
- Direction change mid-run: continue from the current value in the new direction; no reload, no pulse.
- `period`, `prescale` and `upnotdown` are sampled every cycle with no shadowing. The register block owns any synchronisation of 16-bit halves.

## Timing

- `counter_val` changes on the same edge at which `tick` is true. There is no extra pipeline stage.
- `cycle_end` is high for exactly one clock, coincident with the wrapped `counter_val` value (0 in up mode, `period` in down mode).
- After `rst` or `count_reset` deasserts with `en`=1 and `prescale`=P, the first increment lands on the (P+1)th edge.
- `en` rising: counting resumes from the held `psc_cnt`; no cycles are lost or added.
- `rst` or `count_reset` asserted on a wrap edge: the reset wins and `cycle_end` stays 0.

## Structure

- Shared package `pwm_pkg` holds `COUNTER_W`=16, `PRESCALE_W`=8 and the `counter_dir_e` enum (`DIR_DOWN`=0, `DIR_UP`=1). The register block uses the same package.
- One sub-module, `pwm_prescaler` (`clk`, `rst`, `en`, `clr`, `prescale` → `tick`), holds `psc_cnt`.
- `pwm_counter` holds the count register, direction and wrap logic, and the `cycle_end` register.

## Test plan

- Reset, then `en`=1, up, `period`=4, `prescale`=0 → `counter_val` sequence 1,2,3,4,0,1. `cycle_end` high only in the cycle `counter_val`=0.
- Up, `period`=3, `prescale`=2 → each value held 3 clocks. Wrap to 0 after 12 clocks, with one `cycle_end` pulse.
- Down, `period`=5, `prescale`=0, starting from 0 → first tick loads 5 with `cycle_end`=1, then 4,3,2,1,0,5.
- Up at `counter_val`=10, `period` changed to 6 → next tick gives 0 with `cycle_end`=1. Then in down mode at `counter_val`=10 with `period`=6 → next tick gives 6, `cycle_end`=0.
- `en` dropped for 7 clocks mid-prescale (`prescale`=3, `psc_cnt`=2) → `counter_val` and `psc_cnt` frozen; the increment occurs 2 clocks after `en` returns.
- `count_reset` pulsed while `counter_val`=9 and on a wrap edge → `counter_val`=0, `cycle_end`=0, prescaler restarted. Sync `rst` mid-count gives the same result on the next edge.
